// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, state and display encodings for the calculator sequencer
package calc_pkg;

    localparam logic [4:0] KEY_OP_BASE   = 5'h10;
    localparam logic [4:0] KEY_EQ        = 5'h18;
    localparam logic [4:0] KEY_CLR       = 5'h19;
    localparam logic [4:0] KEY_CIN       = 5'h1A;
    localparam logic [4:0] KEY_RSVD_BASE = 5'h1B;

    typedef enum logic [1:0] {
        ENTER_X = 2'd0,
        ENTER_Y = 2'd1,
        EXEC    = 2'd2,
        SHOW    = 2'd3
    } calc_state_e;

    typedef enum logic [1:0] {
        DISP_X   = 2'd0,
        DISP_Y   = 2'd1,
        DISP_RES = 2'd2
    } disp_sel_e;

endpackage

// File: rtl/calc_sequencer_if.sv
// rtl/calc_sequencer_if.sv - key, ALU and display signal bundle around the calculator sequencer
interface calc_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ANS_W  = 16
);
    logic              key_valid;
    logic [4:0]        key_code;
    logic [DATA_W-1:0] X;
    logic [DATA_W-1:0] Y;
    logic [2:0]        S;
    logic              cin;
    logic              alu_go;
    logic [ANS_W-1:0]  alu_ans;
    logic              alu_exceed;
    logic [ANS_W-1:0]  result;
    logic              result_exceed;
    logic              busy;
    logic              key_drop;
    logic [1:0]        disp_sel;

    modport master (
        input  key_valid, key_code, alu_ans, alu_exceed,
        output X, Y, S, cin, alu_go, result, result_exceed, busy, key_drop, disp_sel
    );

    modport slave (
        output key_valid, key_code, alu_ans, alu_exceed,
        input  X, Y, S, cin, alu_go, result, result_exceed, busy, key_drop, disp_sel
    );
endinterface

// File: rtl/calc_key_decode.sv
// rtl/calc_key_decode.sv - combinational classification of a 5-bit key token
module calc_key_decode
    import calc_pkg::*;
(
    input  logic [4:0] key_code,
    output logic       is_digit,
    output logic       is_op,
    output logic       is_eq,
    output logic       is_clr,
    output logic       is_cin,
    output logic       is_rsvd,
    output logic [3:0] nibble,
    output logic [2:0] op
);

    // Token classes are mutually exclusive and cover all 32 codes
    always_comb begin
        is_digit = ~key_code[4];
        is_op    = (key_code[4:3] == KEY_OP_BASE[4:3]);
        is_eq    = (key_code == KEY_EQ);
        is_clr   = (key_code == KEY_CLR);
        is_cin   = (key_code == KEY_CIN);
        is_rsvd  = (key_code >= KEY_RSVD_BASE);
        nibble   = key_code[3:0];
        op       = key_code[2:0];
    end

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad-driven sequencer that assembles operands and runs the ALU
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ANS_W   = 16,
    parameter int ALU_LAT = 1
) (
    input logic              clk,
    input logic              rst_n,
    calc_sequencer_if.master bus
);

    // Last counter value of EXEC; the capture edge closes the ALU_LAT-th busy cycle
    localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);

    calc_state_e       state, state_nxt;
    disp_sel_e         disp, disp_nxt;
    logic [DATA_W-1:0] x_val, x_nxt;
    logic [DATA_W-1:0] y_val, y_nxt;
    logic [2:0]        s_val, s_nxt;
    logic              cin_val, cin_nxt;
    logic [ANS_W-1:0]  res_val, res_nxt;
    logic              exc_val, exc_nxt;
    logic              go_val, go_nxt;
    logic              busy_val, busy_nxt;
    logic              drop_val, drop_nxt;
    logic [3:0]        cnt, cnt_nxt;

    logic       is_digit, is_op, is_eq, is_clr, is_cin, is_rsvd;
    logic [3:0] nibble;
    logic [2:0] op;

    calc_key_decode u_decode (
        .key_code (bus.key_code),
        .is_digit (is_digit),
        .is_op    (is_op),
        .is_eq    (is_eq),
        .is_clr   (is_clr),
        .is_cin   (is_cin),
        .is_rsvd  (is_rsvd),
        .nibble   (nibble),
        .op       (op)
    );

    // State and datapath registers; reset and clear share the same idle values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ENTER_X;
            disp     <= DISP_X;
            x_val    <= '0;
            y_val    <= '0;
            s_val    <= '0;
            cin_val  <= 1'b0;
            res_val  <= '0;
            exc_val  <= 1'b0;
            go_val   <= 1'b0;
            busy_val <= 1'b0;
            drop_val <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            disp     <= disp_nxt;
            x_val    <= x_nxt;
            y_val    <= y_nxt;
            s_val    <= s_nxt;
            cin_val  <= cin_nxt;
            res_val  <= res_nxt;
            exc_val  <= exc_nxt;
            go_val   <= go_nxt;
            busy_val <= busy_nxt;
            drop_val <= drop_nxt;
            cnt      <= cnt_nxt;
        end
    end

    // Next-state and next-output decision for each key token and the EXEC countdown
    always_comb begin
        state_nxt = state;
        disp_nxt  = disp;
        x_nxt     = x_val;
        y_nxt     = y_val;
        s_nxt     = s_val;
        cin_nxt   = cin_val;
        res_nxt   = res_val;
        exc_nxt   = exc_val;
        go_nxt    = 1'b0;
        busy_nxt  = busy_val;
        drop_nxt  = 1'b0;
        cnt_nxt   = cnt;

        if (bus.key_valid && is_clr) begin
            // Clear wins over everything, including a capture due this same cycle
            state_nxt = ENTER_X;
            disp_nxt  = DISP_X;
            x_nxt     = '0;
            y_nxt     = '0;
            s_nxt     = '0;
            cin_nxt   = 1'b0;
            res_nxt   = '0;
            exc_nxt   = 1'b0;
            busy_nxt  = 1'b0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ENTER_X: begin
                    if (bus.key_valid) begin
                        if (is_rsvd) begin
                            drop_nxt = 1'b1;
                        end else if (is_digit) begin
                            x_nxt = {x_val[DATA_W-5:0], nibble};
                        end else if (is_op) begin
                            s_nxt     = op;
                            y_nxt     = '0;
                            state_nxt = ENTER_Y;
                            disp_nxt  = DISP_Y;
                        end else if (is_cin) begin
                            cin_nxt = ~cin_val;
                        end
                    end
                end

                ENTER_Y: begin
                    if (bus.key_valid) begin
                        if (is_rsvd) begin
                            drop_nxt = 1'b1;
                        end else if (is_digit) begin
                            y_nxt = {y_val[DATA_W-5:0], nibble};
                        end else if (is_op) begin
                            s_nxt = op;
                        end else if (is_eq) begin
                            go_nxt    = 1'b1;
                            busy_nxt  = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = EXEC;
                        end else if (is_cin) begin
                            cin_nxt = ~cin_val;
                        end
                    end
                end

                EXEC: begin
                    // No token queue: anything but clear arriving now is lost
                    if (bus.key_valid) begin
                        drop_nxt = 1'b1;
                    end
                    if (cnt == CNT_LAST) begin
                        res_nxt   = bus.alu_ans;
                        exc_nxt   = bus.alu_exceed;
                        busy_nxt  = 1'b0;
                        disp_nxt  = DISP_RES;
                        cnt_nxt   = '0;
                        state_nxt = SHOW;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end

                SHOW: begin
                    if (bus.key_valid) begin
                        if (is_rsvd) begin
                            drop_nxt = 1'b1;
                        end else if (is_digit) begin
                            x_nxt     = {{(DATA_W-4){1'b0}}, nibble};
                            y_nxt     = '0;
                            state_nxt = ENTER_X;
                            disp_nxt  = DISP_X;
                        end else if (is_op) begin
                            x_nxt     = res_val[DATA_W-1:0];
                            s_nxt     = op;
                            y_nxt     = '0;
                            state_nxt = ENTER_Y;
                            disp_nxt  = DISP_Y;
                        end else if (is_eq) begin
                            // Repeat the last operation with the previous answer as X
                            x_nxt     = res_val[DATA_W-1:0];
                            go_nxt    = 1'b1;
                            busy_nxt  = 1'b1;
                            cnt_nxt   = '0;
                            disp_nxt  = DISP_Y;
                            state_nxt = EXEC;
                        end else if (is_cin) begin
                            cin_nxt = ~cin_val;
                        end
                    end
                end

                default: begin
                    state_nxt = ENTER_X;
                end
            endcase
        end
    end

    assign bus.X             = x_val;
    assign bus.Y             = y_val;
    assign bus.S             = s_val;
    assign bus.cin           = cin_val;
    assign bus.alu_go        = go_val;
    assign bus.result        = res_val;
    assign bus.result_exceed = exc_val;
    assign bus.busy          = busy_val;
    assign bus.key_drop      = drop_val;
    assign bus.disp_sel      = disp;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - self-checking bench for calc_sequencer with a two-cycle ALU stand-in
module tb_calc_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   go_count = 0;
    int   base;
    logic [8:0] alu_sum;

    int m_x, m_y, m_s, m_cin, m_res, m_exc, m_mode;
    bit exp_go, exp_drop;
    logic [4:0] k;

    always #5 clk = ~clk;

    calc_sequencer_if #(.DATA_W(8), .ANS_W(16)) bus ();

    calc_sequencer #(.DATA_W(8), .ANS_W(16), .ALU_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ALU stand-in: answer valid one edge after alu_go, garbage otherwise
    always @(posedge clk) begin
        if (bus.alu_go) begin
            if (bus.S == 3'd1) begin
                alu_sum = {1'b0, bus.X} + {1'b0, bus.Y};
                bus.alu_ans    <= {7'd0, alu_sum};
                bus.alu_exceed <= alu_sum[8];
            end else begin
                bus.alu_ans    <= {8'd0, bus.X ^ bus.Y};
                bus.alu_exceed <= 1'b0;
            end
        end else begin
            bus.alu_ans    <= 16'hBEEF;
            bus.alu_exceed <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (bus.alu_go === 1'b1) go_count <= go_count + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge after the DUT has registered the key
    task automatic press(input logic [4:0] code);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 5'h00;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", 32'(n < 20), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_X"}, bus.X, 0);
        chk({tag, "_Y"}, bus.Y, 0);
        chk({tag, "_S"}, bus.S, 0);
        chk({tag, "_cin"}, bus.cin, 0);
        chk({tag, "_result"}, bus.result, 0);
        chk({tag, "_exceed"}, bus.result_exceed, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_go"}, bus.alu_go, 0);
        chk({tag, "_disp"}, bus.disp_sel, 0);
    endtask

    // Reference calculator: mode 0 entering X, 1 entering Y, 2 showing an answer
    task automatic model_key(input int kc, output bit go, output bit drop);
        go = 1'b0;
        drop = 1'b0;
        if (kc == 'h19) begin
            m_x = 0; m_y = 0; m_s = 0; m_cin = 0; m_res = 0; m_exc = 0; m_mode = 0;
        end else if (kc >= 'h1B) begin
            drop = 1'b1;
        end else if (kc == 'h1A) begin
            m_cin = 1 - m_cin;
        end else if (kc < 16) begin
            if (m_mode == 0) m_x = (m_x * 16 + kc) % 256;
            else if (m_mode == 1) m_y = (m_y * 16 + kc) % 256;
            else begin m_x = kc; m_y = 0; m_mode = 0; end
        end else if (kc < 'h18) begin
            if (m_mode == 2) m_x = m_res % 256;
            if (m_mode != 1) m_y = 0;
            m_s = kc - 16;
            m_mode = 1;
        end else if (m_mode != 0) begin
            if (m_mode == 2) m_x = m_res % 256;
            if (m_s == 1) begin
                m_res = m_x + m_y;
                m_exc = (m_res > 255) ? 1 : 0;
            end else begin
                m_res = m_x ^ m_y;
                m_exc = 0;
            end
            m_mode = 2;
            go = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code = 5'h00;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset_drop", bus.key_drop, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 12 + 34
        press(5'h01); press(5'h02); press(5'h11); press(5'h03); press(5'h04);
        chk("add_X", bus.X, 8'h12);
        chk("add_Y", bus.Y, 8'h34);
        chk("add_S", bus.S, 3'd1);
        chk("add_disp", bus.disp_sel, 1);
        base = go_count;
        press(5'h18);
        chk("add_go1", bus.alu_go, 1);
        chk("add_busy1", bus.busy, 1);
        @(negedge clk);
        chk("add_go2", bus.alu_go, 0);
        chk("add_busy2", bus.busy, 1);
        @(negedge clk);
        chk("add_busy3", bus.busy, 0);
        chk("add_result", bus.result, 16'h0046);
        chk("add_exceed", bus.result_exceed, 0);
        chk("add_disp_res", bus.disp_sel, 2);
        chk("add_go_count", go_count - base, 1);

        // repeat last op from SHOW
        press(5'h18);
        chk("rep_X", bus.X, 8'h46);
        chk("rep_Y", bus.Y, 8'h34);
        wait_idle();
        chk("rep_result", bus.result, 16'h007A);

        press(5'h19);
        chk_idle("clear");

        // FF + 01 overflow, then chain
        press(5'h0F); press(5'h0F); press(5'h11); press(5'h00); press(5'h01); press(5'h18);
        wait_idle();
        chk("ovf_result", bus.result, 16'h0100);
        chk("ovf_exceed", bus.result_exceed, 1);
        press(5'h11); press(5'h00); press(5'h02); press(5'h18);
        chk("chain_X", bus.X, 8'h00);
        chk("chain_Y", bus.Y, 8'h02);
        wait_idle();
        chk("chain_result", bus.result, 16'h0002);
        chk("chain_exceed", bus.result_exceed, 0);

        // wrap-around and ignored equals
        press(5'h19);
        press(5'h01); press(5'h02); press(5'h03);
        chk("wrap_X", bus.X, 8'h23);
        base = go_count;
        press(5'h18);
        @(negedge clk);
        chk("eqx_go_count", go_count - base, 0);
        chk("eqx_disp", bus.disp_sel, 0);
        chk("eqx_busy", bus.busy, 0);
        chk("eqx_drop", bus.key_drop, 0);

        // equals during EXEC is dropped
        press(5'h11); press(5'h05);
        base = go_count;
        press(5'h18);
        press(5'h18);
        chk("exec_drop", bus.key_drop, 1);
        chk("exec_go", bus.alu_go, 0);
        chk("exec_busy", bus.busy, 1);
        wait_idle();
        @(negedge clk);
        chk("exec_go_count", go_count - base, 1);
        chk("exec_result", bus.result, 16'h0028);

        // clear during EXEC aborts the capture
        press(5'h11); press(5'h01);
        base = go_count;
        press(5'h18);
        press(5'h19);
        chk_idle("clr_exec");
        repeat (4) @(negedge clk);
        chk("clr_exec_late_result", bus.result, 0);
        chk("clr_exec_go_count", go_count - base, 1);

        // reserved code and carry toggle
        press(5'h07);
        press(5'h1C);
        chk("rsvd_drop", bus.key_drop, 1);
        chk("rsvd_X", bus.X, 8'h07);
        press(5'h1A);
        chk("cin_toggle", bus.cin, 1);
        chk("cin_drop", bus.key_drop, 0);

        // async reset one cycle after alu_go
        press(5'h11); press(5'h09); press(5'h18);
        chk("rst_go", bus.alu_go, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        base = go_count;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_idle("post_rst");
        chk("post_rst_go_count", go_count - base, 0);

        // randomized tokens against the reference calculator
        m_x = 0; m_y = 0; m_s = 0; m_cin = 0; m_res = 0; m_exc = 0; m_mode = 0;
        for (int i = 0; i < 300; i++) begin
            k = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) k = 5'h18;
            model_key(int'(k), exp_go, exp_drop);
            press(k);
            chk("rnd_go", bus.alu_go, 32'(exp_go));
            chk("rnd_drop", bus.key_drop, 32'(exp_drop));
            if (exp_go) wait_idle();
            chk("rnd_X", bus.X, m_x);
            chk("rnd_Y", bus.Y, m_y);
            chk("rnd_S", bus.S, m_s);
            chk("rnd_cin", bus.cin, m_cin);
            chk("rnd_disp", bus.disp_sel, m_mode);
            chk("rnd_result", bus.result, m_res);
            chk("rnd_exceed", bus.result_exceed, m_exc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
